// File: rtl/mult_pkg.sv
// Shared types for the two-requester multiply scheduler.
package mult_pkg;

  localparam int unsigned DefaultW = 32;

  // RV32M multiply flavours, encoded as carried on req_op
  typedef enum logic [1:0] {
    OpMul    = 2'b00,
    OpMulh   = 2'b01,
    OpMulhsu = 2'b10,
    OpMulhu  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant,
  output logic       o_id
);

  // Pick the winner and form the matching one-hot grant
  always_comb begin
    o_id = 1'b0;
    case (i_valid)
      2'b10:   o_id = 1'b1;
      2'b11:   o_id = ~i_last;
      default: o_id = 1'b0;
    endcase
    o_grant = i_valid & (o_id ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one external signed (W+1)x(W+1) multiplier between two requesters,
// one transaction in flight at a time.
module mult_scheduler
  import mult_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic                 i_reloj,
  input  logic                 i_reset,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic [1:0][1:0]      i_req_op,
  input  logic [1:0][W-1:0]    i_req_a,
  input  logic [1:0][W-1:0]    i_req_b,
  output logic [1:0]           o_resp_valid,
  output logic [1:0][W-1:0]    o_resp_data,
  input  logic [1:0]           i_resp_ready,
  output logic                 o_mul_start,
  output logic [W:0]           o_mul_a,
  output logic [W:0]           o_mul_b,
  input  logic                 i_mul_done,
  input  logic [2*W-1:0]       i_mul_s,
  output logic                 o_busy
);

  state_e     r_state, w_state_d;
  mul_op_e    r_op;
  logic [W:0] r_a, r_b;
  logic       r_id;
  logic       r_last;
  logic [W-1:0] r_result;

  logic [1:0]   w_grant;
  logic         w_grant_id;
  logic         w_accept;
  mul_op_e      w_op;
  logic [W-1:0] w_a, w_b;
  logic         w_sign_a, w_sign_b;

  rr_arbiter2 u_arb (
    .i_valid (i_req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_id    (w_grant_id)
  );

  // A request is taken only from IDLE and never while reset is asserted
  assign w_accept = (r_state == StIdle) && !i_reset && (|i_req_valid);
  assign w_op     = mul_op_e'(i_req_op[w_grant_id]);
  assign w_a      = i_req_a[w_grant_id];
  assign w_b      = i_req_b[w_grant_id];
  assign w_sign_a = (w_op != OpMulhu);
  assign w_sign_b = (w_op == OpMul) || (w_op == OpMulh);
  assign o_busy   = (r_state != StIdle);

  // State register
  always_ff @(posedge i_reloj) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next state and all handshake/multiplier-facing outputs
  always_comb begin
    w_state_d    = r_state;
    o_req_ready  = '0;
    o_resp_valid = '0;
    o_resp_data  = '0;
    o_mul_start  = 1'b0;
    o_mul_a      = '0;
    o_mul_b      = '0;
    unique case (r_state)
      StIdle: begin
        if (!i_reset) o_req_ready = w_grant;
        if (w_accept) w_state_d = StIssue;
      end
      StIssue: begin
        o_mul_start = 1'b1;
        o_mul_a     = r_a;
        o_mul_b     = r_b;
        w_state_d   = StWait;
      end
      StWait: begin
        o_mul_a = r_a;
        o_mul_b = r_b;
        if (i_mul_done) w_state_d = StResp;
      end
      StResp: begin
        o_resp_valid[r_id] = 1'b1;
        o_resp_data[r_id]  = r_result;
        if (i_resp_ready[r_id]) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Transaction capture, result capture and last-grant tracking
  always_ff @(posedge i_reloj) begin
    if (i_reset) begin
      r_op     <= OpMul;
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= 1'b0;
      r_result <= '0;
      r_last   <= 1'b1;
    end else begin
      if (w_accept) begin
        r_op <= w_op;
        r_a  <= {w_sign_a & w_a[W-1], w_a};
        r_b  <= {w_sign_b & w_b[W-1], w_b};
        r_id <= w_grant_id;
      end
      if ((r_state == StWait) && i_mul_done) begin
        r_result <= (r_op == OpMul) ? i_mul_s[W-1:0] : i_mul_s[2*W-1:W];
      end
      if ((r_state == StResp) && i_resp_ready[r_id]) begin
        r_last <= r_id;
      end
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler: transaction-level model plus directed vectors.
module tb_mult_scheduler;

  localparam int unsigned W = 32;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0][1:0]   req_op;
  logic [1:0][W-1:0] req_a, req_b, resp_data;
  logic              mul_start, mul_done, busy;
  logic [W:0]        mul_a, mul_b;
  logic [2*W-1:0]    mul_s;

  logic              env_done, spur_done;
  logic [2*W-1:0]    env_s;
  int                mul_lat;
  bit                cmp_en;

  int n_checks = 0;
  int n_errors = 0;

  assign mul_done = env_done | spur_done;
  assign mul_s    = spur_done ? 64'h0123_4567_89AB_CDEF : env_s;

  mult_scheduler #(.W(W)) dut (
    .i_reloj      (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_resp_valid (resp_valid),
    .o_resp_data  (resp_data),
    .i_resp_ready (resp_ready),
    .o_mul_start  (mul_start),
    .o_mul_a      (mul_a),
    .o_mul_b      (mul_b),
    .i_mul_done   (mul_done),
    .i_mul_s      (mul_s),
    .o_busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference behaviour ----------------
  function automatic logic [1:0] rr(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic logic [32:0] ext(input logic [31:0] x, input logic s);
    return {s & x[31], x};
  endfunction

  // Architectural RV32M result from the original 32-bit operands
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00:   begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      2'b01:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      2'b10:   begin p = {{32{a[31]}}, a} * {32'h0, b}; return p[63:32]; end
      default: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
    endcase
  endfunction

  // Transaction model: one request in flight, start next cycle, result after done
  bit          m_active = 0, m_start_due = 0, m_res_valid = 0, m_id = 0, m_last = 1;
  logic [31:0] m_exp = '0;
  logic [32:0] m_ea = '0, m_eb = '0;

  always @(posedge clk) begin : mdl
    logic [1:0] g;
    logic [1:0] op;
    if (rst) begin
      m_active    <= 0;
      m_start_due <= 0;
      m_res_valid <= 0;
      m_last      <= 1;
    end else if (!m_active) begin
      if (|req_valid) begin
        g  = rr(req_valid, m_last);
        op = req_op[g[1]];
        m_active    <= 1;
        m_start_due <= 1;
        m_id        <= g[1];
        m_exp       <= ref_res(op, req_a[g[1]], req_b[g[1]]);
        m_ea        <= ext(req_a[g[1]], op != 2'b11);
        m_eb        <= ext(req_b[g[1]], op < 2'b10);
      end
    end else if (m_start_due) begin
      m_start_due <= 0;
    end else if (!m_res_valid) begin
      if (mul_done) m_res_valid <= 1;
    end else if (resp_ready[m_id]) begin
      m_active    <= 0;
      m_res_valid <= 0;
      m_last      <= m_id;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin : cmp
    logic [1:0]  e_rdy, e_rv;
    logic [63:0] e_rd;
    logic [32:0] e_a, e_b;
    if (cmp_en) begin
      e_rdy = (!rst && !m_active) ? rr(req_valid, m_last) : 2'b00;
      e_rv  = m_res_valid ? (m_id ? 2'b10 : 2'b01) : 2'b00;
      e_rd  = !m_res_valid ? 64'h0 : (m_id ? {m_exp, 32'h0} : {32'h0, m_exp});
      e_a   = (m_active && !m_res_valid) ? m_ea : 33'h0;
      e_b   = (m_active && !m_res_valid) ? m_eb : 33'h0;
      chk("busy", busy, m_active);
      chk("req_ready", req_ready, e_rdy);
      chk("mul_start", mul_start, m_active && m_start_due);
      chk("mul_a", mul_a, e_a);
      chk("mul_b", mul_b, e_b);
      chk("resp_valid", resp_valid, e_rv);
      chk("resp_data", resp_data, e_rd);
    end
  end

  // Multiplier environment: signed product of the extended operands
  initial begin : env
    logic signed [65:0] ea, eb, p;
    env_done = 1'b0;
    env_s    = '0;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        ea = {{33{mul_a[32]}}, mul_a};
        eb = {{33{mul_b[32]}}, mul_b};
        p  = ea * eb;
        @(posedge clk);
        repeat (mul_lat) @(posedge clk);
        #1;
        env_done = 1'b1;
        env_s    = p[63:0];
        @(posedge clk);
        #1;
        env_done = 1'b0;
        env_s    = 64'hFFFF_0000_FFFF_0000;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input int id, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    bit got;
    got = 0;
    req_op[id]    = op;
    req_a[id]     = a;
    req_b[id]     = b;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    chk("handshake", got, 1);
  endtask

  task automatic collect(input int id, input logic [31:0] exp, input string name,
                         input int hold, output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (lat < 60 && !got) begin
      @(negedge clk);
      lat++;
      if (resp_valid[id]) got = 1;
    end
    chk({name, "_valid"}, got, 1);
    if (got) begin
      chk({name, "_data"}, resp_data[id], exp);
      chk({name, "_other"}, resp_valid[1-id], 0);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        spur_done = (k == 1);
        chk({name, "_hold_busy"}, busy, 1);
        chk({name, "_hold_rdy"}, req_ready, 0);
        chk({name, "_hold_start"}, mul_start, 0);
        chk({name, "_hold_valid"}, resp_valid[id], 1);
        chk({name, "_hold_data"}, resp_data[id], exp);
      end
      spur_done = 1'b0;
      @(posedge clk);
      #1;
      resp_ready[id] = 1'b1;
      @(posedge clk);
      #1;
      resp_ready[id] = 1'b0;
    end
  endtask

  initial begin
    int lat;
    rst        = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    spur_done  = 1'b0;
    mul_lat    = 0;
    cmp_en     = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1;

    // Reset state, including a request held during reset
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mul_a", mul_a, 0);
    @(posedge clk);
    #1;
    req_valid = 2'b01;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_start", mul_start, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b0;

    // Basic MUL with fastest multiplier; latency from handshake edge
    send(0, 2'b00, 32'd7, 32'hFFFF_FFFD);
    collect(0, 32'hFFFF_FFEB, "mul_neg", 0, lat);
    chk("latency", lat, 3);

    // High-half variants on all-ones operands
    send(1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect(1, 32'hFFFF_FFFE, "mulhu", 0, lat);
    send(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect(0, 32'h0000_0000, "mulh", 0, lat);
    send(1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect(1, 32'hFFFF_FFFF, "mulhsu", 0, lat);

    // Stray done while idle
    @(posedge clk);
    #1;
    spur_done = 1'b1;
    @(posedge clk);
    #1;
    spur_done = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", busy, 0);
    @(posedge clk);
    #1;

    // Back-pressure with the other requester waiting, plus a stray done in RESP
    mul_lat = 1;
    send(0, 2'b00, 32'h1234_5678, 32'h0000_0010);
    req_op[1]    = 2'b11;
    req_a[1]     = 32'h8000_0000;
    req_b[1]     = 32'h0000_0002;
    req_valid[1] = 1'b1;
    collect(0, 32'h2345_6780, "hold", 5, lat);
    send(1, 2'b11, 32'h8000_0000, 32'h0000_0002);
    collect(1, 32'h0000_0001, "after_hold", 0, lat);

    // Round-robin from reset with both requesters held valid
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    mul_lat = 2;
    req_op  = '0;
    req_a[0] = 32'd3;
    req_b[0] = 32'd5;
    req_a[1] = 32'd16;
    req_b[1] = 32'd16;
    req_valid = 2'b11;
    collect(0, 32'd15, "rr0", 0, lat);
    collect(1, 32'd256, "rr1", 0, lat);
    collect(0, 32'd15, "rr2", 0, lat);
    collect(1, 32'd256, "rr3", 0, lat);
    req_valid = '0;

    // Reset while waiting on the multiplier; its late done must be dropped
    mul_lat = 6;
    send(1, 2'b00, 32'd5, 32'd6);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rst_wait_valid", resp_valid, 0);
      chk("rst_wait_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    mul_lat = 0;
    send(0, 2'b11, 32'h8000_0000, 32'd4);
    collect(0, 32'h0000_0002, "post_rst", 0, lat);
    chk("latency2", lat, 3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
